// File: rtl/arbitro_pkg.sv
// Shared definitions for the round-robin arbitrated adder/subtractor:
// FSM state encodings and operation codes.
package arbitro_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } estado_t;

   localparam logic OP_SOMA = 1'b0;
   localparam logic OP_SUB  = 1'b1;

endpackage

// File: rtl/somador_subtrator8bits.sv
// Combinational WIDTH-bit adder/subtractor shared by all requesters.
// Bit WIDTH of s is the carry on add and the no-borrow flag (a >= b) on subtract.
module somador_subtrator8bits
   import arbitro_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic [WIDTH:0]   s
);

   logic [WIDTH-1:0] b_sel;
   logic             cin;

   // Subtraction as a + ~b + 1 keeps a single carry chain for both operations.
   always_comb begin
      b_sel = (op == OP_SUB) ? ~b : b;
      cin   = (op == OP_SUB);
      s     = {1'b0, a} + {1'b0, b_sel} + {{WIDTH{1'b0}}, cin};
   end

endmodule

// File: rtl/arbitro_somador.sv
// Round-robin arbiter sharing one adder/subtractor among N_REQ requesters.
// Each grant runs IDLE -> CALC -> DONE; valido/ack pulse for the DONE cycle only.
module arbitro_somador
   import arbitro_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int WIDTH = 8,
   localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ-1:0]       op,
   input  logic [N_REQ*WIDTH-1:0] a_in,
   input  logic [N_REQ*WIDTH-1:0] b_in,
   output logic [N_REQ-1:0]       ack,
   output logic [WIDTH:0]         resultado,
   output logic                   valido,
   output logic [IDW-1:0]         id,
   output logic                   ocupado
);

   estado_t          state;
   estado_t          next_state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   idx_q;
   logic [IDW-1:0]   grant_idx;
   logic             grant_any;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             op_q;
   logic [WIDTH:0]   soma;

   // Search starts just after the last served index, so a requester that
   // keeps req high after its ack waits behind every other pending one.
   always_comb begin
      logic [IDW-1:0] cand;
      cand      = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDW'((int'(ptr) + k) % N_REQ);
         if (!grant_any && req[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (grant_any) next_state = CALC;
         CALC:    next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      ocupado = (state != IDLE);
      valido  = (state == DONE);
      ack     = '0;
      if (state == DONE) ack[id] = 1'b1;
   end

   somador_subtrator8bits #(
      .WIDTH(WIDTH)
   ) u_somador (
      .a  (a_q),
      .b  (b_q),
      .op (op_q),
      .s  (soma)
   );

   // Operands are captured at grant so later changes on a_in/b_in/op/req
   // cannot disturb the operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= IDW'(N_REQ - 1);
         idx_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= OP_SOMA;
         resultado <= '0;
         id        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  idx_q <= grant_idx;
                  a_q   <= a_in[int'(grant_idx)*WIDTH +: WIDTH];
                  b_q   <= b_in[int'(grant_idx)*WIDTH +: WIDTH];
                  op_q  <= op[grant_idx];
               end
            end
            CALC: begin
               resultado <= soma;
               id        <= idx_q;
            end
            DONE: ptr <= id;
            default: ;
         endcase
      end
   end

endmodule
